// File: rtl/cargador_serial_pkg.sv
// Shared definitions for the serial loader: state encoding and the cuenta width helper.
package cargador_serial_pkg;

  localparam logic [1:0] VACIO    = 2'd0;
  localparam logic [1:0] CARGANDO = 2'd1;
  localparam logic [1:0] LLENO    = 2'd2;

  // Also used by the comparison network's bench to size its count ports.
  function automatic int cuenta_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/cargador_serial_contador_carga.sv
// Saturating up-counter of accepted pairs, with synchronous clear and a full flag.
module contador_carga
  import cargador_serial_pkg::*;
#(
  parameter int N = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr,
  input  logic                   en,
  output logic [cuenta_w(N)-1:0] cuenta,
  output logic                   lleno
);

  localparam int CW = cuenta_w(N);
  localparam logic [CW-1:0] TOPE = CW'(N);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cuenta <= '0;
    end else if (clr) begin
      cuenta <= '0;
    end else if (en && (cuenta != TOPE)) begin
      cuenta <= cuenta + CW'(1);
    end
  end

  assign lleno = (cuenta == TOPE);

endmodule

// File: rtl/cargador_serial.sv
// Serial-to-parallel loader feeding the comparison network, LSB pair first.
// Optional sticky overrun flag error_o when CARGADOR_ERROR_EN is defined.
//
//   state    | meaning
//   VACIO    | no pairs held, cuenta = 0
//   CARGANDO | partial word, 0 < cuenta < N
//   LLENO    | complete word presented, waiting for ack
module cargador_serial
  import cargador_serial_pkg::*;
#(
  parameter int N = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   borrar_i,
  input  logic                   bit_a_i,
  input  logic                   bit_b_i,
  input  logic                   bit_valido_i,
  output logic                   bit_listo_o,
  output logic [N-1:0]           A_o,
  output logic [N-1:0]           B_o,
  output logic                   palabra_valida_o,
  input  logic                   palabra_ack_i,
  output logic [cuenta_w(N)-1:0] cuenta_o
`ifdef CARGADOR_ERROR_EN
  ,
  output logic                   error_o
`endif
);

  localparam int CW = cuenta_w(N);
  localparam logic [CW-1:0] ULTIMO = CW'(N - 1);

  logic [1:0] estado;
  logic       acepta;
  logic       vaciar;
  logic       lleno;

  assign bit_listo_o      = (estado != LLENO);
  assign palabra_valida_o = (estado == LLENO);

  // The counter's full flag also guards the write index against overrun.
  assign acepta = bit_valido_i & bit_listo_o & ~lleno;
  assign vaciar = borrar_i | (palabra_valida_o & palabra_ack_i);

  contador_carga #(.N(N)) u_contador (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (vaciar),
    .en     (acepta),
    .cuenta (cuenta_o),
    .lleno  (lleno)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado <= VACIO;
    end else if (vaciar) begin
      estado <= VACIO;
    end else begin
      case (estado)
        VACIO:    if (acepta) estado <= CARGANDO;
        CARGANDO: if (acepta && (cuenta_o == ULTIMO)) estado <= LLENO;
        LLENO:    estado <= LLENO;
        default:  estado <= VACIO;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      A_o <= '0;
      B_o <= '0;
    end else if (vaciar) begin
      A_o <= '0;
      B_o <= '0;
    end else if (acepta) begin
      for (int i = 0; i < N; i++) begin
        if (cuenta_o == CW'(i)) begin
          A_o[i] <= bit_a_i;
          B_o[i] <= bit_b_i;
        end
      end
    end
  end

`ifdef CARGADOR_ERROR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      error_o <= 1'b0;
    end else if (borrar_i) begin
      error_o <= 1'b0;
    end else if (bit_valido_i && !bit_listo_o) begin
      error_o <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_cargador_serial.sv
// Scoreboard bench for cargador_serial (N=3): stimulus queues expected words, a monitor checks them.
module tb_cargador_serial;

  localparam int N = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic borrar = 1'b0;
  logic bit_a = 1'b0;
  logic bit_b = 1'b0;
  logic bit_valido = 1'b0;
  logic palabra_ack = 1'b0;
  logic bit_listo;
  logic palabra_valida;
  logic [N-1:0] a_w;
  logic [N-1:0] b_w;
  logic [1:0] cuenta;
`ifdef CARGADOR_ERROR_EN
  logic error;
`endif

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [5:0] sb[$];

  cargador_serial #(.N(N)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .borrar_i         (borrar),
    .bit_a_i          (bit_a),
    .bit_b_i          (bit_b),
    .bit_valido_i     (bit_valido),
    .bit_listo_o      (bit_listo),
    .A_o              (a_w),
    .B_o              (b_w),
    .palabra_valida_o (palabra_valida),
    .palabra_ack_i    (palabra_ack),
    .cuenta_o         (cuenta)
`ifdef CARGADOR_ERROR_EN
    ,
    .error_o          (error)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_pair(input logic a, input logic b);
    int n;
    n = 0;
    bit_a = a;
    bit_b = b;
    bit_valido = 1'b1;
    while (!bit_listo && n < 20) begin
      tick();
      n++;
    end
    if (n == 20) begin
      checks++;
      failures++;
      $display("FAIL send_timeout actual=bit_listo 0 for %0d cycles required=1", n);
    end
    tick();
    bit_valido = 1'b0;
  endtask

  task automatic expect_word(input logic [2:0] a, input logic [2:0] b);
    sb.push_back({a, b});
  endtask

  task automatic ack_pulse();
    palabra_ack = 1'b1;
    tick();
    palabra_ack = 1'b0;
  endtask

  // Monitor: every rising palabra_valida presents one word to compare against the queue.
  logic prev_v = 1'b0;
  always @(negedge clk) begin
    logic [5:0] e;
    if (palabra_valida && !prev_v) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_underflow actual=word %0h/%0h required=no word", a_w, b_w);
      end else begin
        e = sb.pop_front();
        chk("sb_word_a", 32'(a_w), 32'(e[5:3]));
        chk("sb_word_b", 32'(b_w), 32'(e[2:0]));
        chk("sb_word_cuenta", 32'(cuenta), 32'd3);
      end
    end
    prev_v = palabra_valida;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=time %0t required=finish earlier", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] st_a;
    logic [1:0] st_b;
    int t0;
    int gap;

    // reset values
    #12;
    chk("rst_listo", 32'(bit_listo), 32'd1);
    chk("rst_valid", 32'(palabra_valida), 32'd0);
    chk("rst_a", 32'(a_w), 32'd0);
    chk("rst_b", 32'(b_w), 32'd0);
    chk("rst_cuenta", 32'(cuenta), 32'd0);
`ifdef CARGADOR_ERROR_EN
    chk("rst_error", 32'(error), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // basic fill, overrun, ack
    expect_word(3'b010, 3'b000);
    send_pair(1'b0, 1'b0);
    chk("basic_cnt1", 32'(cuenta), 32'd1);
    send_pair(1'b1, 1'b0);
    send_pair(1'b0, 1'b0);
    chk("basic_valid", 32'(palabra_valida), 32'd1);
    chk("basic_listo0", 32'(bit_listo), 32'd0);
    chk("basic_a", 32'(a_w), 32'b010);
    bit_a = 1'b1;
    bit_b = 1'b1;
    bit_valido = 1'b1;
    tick();
    tick();
    bit_valido = 1'b0;
    chk("ovr_a_frozen", 32'(a_w), 32'b010);
    chk("ovr_b_frozen", 32'(b_w), 32'b000);
    chk("ovr_cuenta", 32'(cuenta), 32'd3);
`ifdef CARGADOR_ERROR_EN
    chk("ovr_error_set", 32'(error), 32'd1);
`endif
    ack_pulse();
    chk("ack_valid0", 32'(palabra_valida), 32'd0);
    chk("ack_listo1", 32'(bit_listo), 32'd1);
    chk("ack_a0", 32'(a_w), 32'd0);
    chk("ack_b0", 32'(b_w), 32'd0);
    chk("ack_cuenta0", 32'(cuenta), 32'd0);
`ifdef CARGADOR_ERROR_EN
    chk("error_sticky", 32'(error), 32'd1);
    borrar = 1'b1;
    tick();
    borrar = 1'b0;
    chk("error_cleared", 32'(error), 32'd0);
`endif

    // back-to-back words with ack held high
    palabra_ack = 1'b1;
    expect_word(3'b111, 3'b111);
    expect_word(3'b010, 3'b010);
    send_pair(1'b1, 1'b1);
    send_pair(1'b1, 1'b1);
    send_pair(1'b1, 1'b1);
    chk("b2b_valid1", 32'(palabra_valida), 32'd1);
    t0 = cyc;
    bit_a = 1'b0;
    bit_b = 1'b0;
    bit_valido = 1'b1;
    tick();
    chk("b2b_no_accept_on_ack", 32'(cuenta), 32'd0);
    chk("b2b_listo_after_ack", 32'(bit_listo), 32'd1);
    send_pair(1'b0, 1'b0);
    send_pair(1'b1, 1'b1);
    send_pair(1'b0, 1'b0);
    chk("b2b_valid2", 32'(palabra_valida), 32'd1);
    chk("b2b_period", 32'(cyc - t0), 32'd4);
    tick();
    palabra_ack = 1'b0;
    chk("b2b_released", 32'(palabra_valida), 32'd0);

    // borrar and ack together in LLENO
    expect_word(3'b101, 3'b001);
    send_pair(1'b1, 1'b1);
    send_pair(1'b0, 1'b0);
    send_pair(1'b1, 1'b0);
    bit_valido = 1'b1;
    tick();
    bit_valido = 1'b0;
    borrar = 1'b1;
    palabra_ack = 1'b1;
    tick();
    borrar = 1'b0;
    palabra_ack = 1'b0;
    chk("clr_valid0", 32'(palabra_valida), 32'd0);
    chk("clr_listo1", 32'(bit_listo), 32'd1);
    chk("clr_a0", 32'(a_w), 32'd0);
    chk("clr_b0", 32'(b_w), 32'd0);
    chk("clr_cuenta0", 32'(cuenta), 32'd0);
`ifdef CARGADOR_ERROR_EN
    chk("clr_error0", 32'(error), 32'd0);
`endif

    // asynchronous reset mid-word
    send_pair(1'b1, 1'b1);
    send_pair(1'b1, 1'b1);
    chk("mid_cuenta2", 32'(cuenta), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_cuenta0", 32'(cuenta), 32'd0);
    chk("async_a0", 32'(a_w), 32'd0);
    chk("async_b0", 32'(b_w), 32'd0);
    chk("async_listo1", 32'(bit_listo), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    expect_word(3'b011, 3'b101);
    send_pair(1'b1, 1'b1);
    send_pair(1'b1, 1'b0);
    send_pair(1'b0, 1'b1);
    chk("post_rst_a", 32'(a_w), 32'b011);
    chk("post_rst_b", 32'(b_w), 32'b101);
    ack_pulse();

    // stalled producer
    st_a = 2'b0;
    st_b = 2'b0;
    expect_word(3'b101, 3'b110);
    for (int i = 0; i < 3; i++) begin
      gap = $urandom_range(1, 5);
      repeat (gap) begin
        tick();
        chk("stall_cnt_hold", 32'(cuenta), 32'(i));
      end
      case (i)
        0: send_pair(1'b1, 1'b0);
        1: send_pair(1'b0, 1'b1);
        default: send_pair(1'b1, 1'b1);
      endcase
      chk("stall_cnt_inc", 32'(cuenta), 32'(i + 1));
    end
    chk("stall_a", 32'(a_w), 32'b101);
    chk("stall_b", 32'(b_w), 32'b110);
    ack_pulse();
    tick();

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cargador_serial.md
# cargador_serial

Serial-to-parallel loader that sits directly upstream of the right-to-left iterative comparison network. It receives one (A,B) bit pair per clock, least-significant position first, through a valid/ready handshake. It assembles the two N-bit words and presents them, held stable, with a word-valid flag until the consumer acknowledges. The network's A and B inputs are driven straight from this block's A_o and B_o.

## Interface
- N, default 3: word width; legal values N ≥ 2.
- clk  input  1  single clock; all state changes on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- borrar_i  input  1  synchronous clear; discards any partial or complete word.
- bit_a_i  input  1  incoming bit of A.
- bit_b_i  input  1  incoming bit of B, paired with bit_a_i.
- bit_valido_i  input  1  pair on bit_a_i/bit_b_i is valid.
- bit_listo_o  output  1  loader accepts a pair this cycle.
- A_o  output  N  assembled word A, to the network.
- B_o  output  N  assembled word B, to the network.
- palabra_valida_o  output  1  A_o/B_o hold a complete word.
- palabra_ack_i  input  1  consumer has taken the word.
- cuenta_o  output  $clog2(N+1)  number of pairs accepted into the current word.
- error_o  output  1  sticky overrun flag; present only with CARGADOR_ERROR_EN.

## Operation
- Reset values: A_o=0, B_o=0, cuenta_o=0, palabra_valida_o=0, bit_listo_o=1, error_o=0; state VACIO.
- States:
  - VACIO: cuenta=0.
  - CARGANDO: 0<cuenta<N.
  - LLENO: cuenta=N.
- bit_listo_o is 1 in VACIO and CARGANDO and 0 in LLENO. It is decoded from the state register, so it is not a combinational path from any input.
- Acceptance: bit_valido_i & bit_listo_o on an edge writes bit_a_i to A_o[cuenta] and bit_b_i to B_o[cuenta], then increments cuenta.
- Fill order is right-to-left: the first pair goes to position 0 and the Nth pair to position N-1.
- Transitions:
  - VACIO→CARGANDO on acceptance.
  - CARGANDO→LLENO on the acceptance that makes cuenta=N.
  - VACIO→LLENO is not possible, because N ≥ 2.
- LLENO: palabra_valida_o=1 and A_o/B_o are frozen. bit_valido_i is ignored, no write occurs, and cuenta is unchanged.
- palabra_ack_i in LLENO: on the next edge, state becomes VACIO, cuenta=0, A_o=0, B_o=0 and palabra_valida_o=0.
- palabra_ack_i outside LLENO is ignored.
- borrar_i has the highest synchronous priority, above acceptance and ack. On the next edge, outputs take their reset values; error_o is also cleared.
- Reset asserted mid-word: outputs return to reset values immediately, independent of clk. The partial word is lost.
- Counter arithmetic is unsigned at the width of cuenta_o. cuenta never exceeds N and never wraps.

## Timing
- Latency: palabra_valida_o rises on the edge that accepts the Nth pair. It is visible in the cycle following that pair's presentation.
- A_o/B_o are valid with palabra_valida_o and remain stable until the edge after ack.
- Minimum period per word is N+1 cycles: N acceptance cycles plus one ack cycle, with palabra_ack_i held high.
- bit_listo_o returns to 1 in the cycle after the ack edge. A pair can therefore be presented in the very next cycle and is accepted.
- A pair presented in the same cycle as an ack in LLENO is not accepted; the producer must hold it.
- All outputs are registered.

## Configuration
- CARGADOR_ERROR_EN defined:
  - error_o exists and is set on any edge where bit_valido_i=1 and bit_listo_o=0, i.e. an overrun in LLENO.
  - error_o stays set until borrar_i or rst_n.
  - It does not affect data or state.
- CARGADOR_ERROR_EN undefined: error_o port and its register are absent. Overruns are silently ignored.

## Structure
- Shared package holds:
  - state encoding constants VACIO=2'd0, CARGANDO=2'd1, LLENO=2'd2;
  - the cuenta width function, shared with the network's testbench.
- One sub-module, contador_carga: a saturating up-counter with synchronous clear and enable, parameterised by N, producing cuenta and a lleno flag. State decode and the shift/write registers stay in cargador_serial.

## Test plan
All scenarios use N=3.
- Basic fill: pairs (0,0),(1,0),(0,0) on consecutive cycles, then ack. Required: A_o=3'b010, B_o=3'b000, palabra_valida_o=1 after the third pair; after ack, all outputs 0 and bit_listo_o=1.
- Back-to-back words: ack held high, bit_valido_i held high with pairs 1,1,1 then 0,1,0. Required: first word A_o=B_o=3'b111; second word A_o=3'b010, B_o=3'b010; 4 cycles per word.
- Overrun, macro on: a 4th pair with bit_valido_i=1 while LLENO. Required: A_o/B_o unchanged, error_o=1 until borrar_i; macro off: port absent and data unchanged.
- borrar_i and ack in the same cycle in LLENO. Required: next cycle all reset values, error_o=0.
- Reset mid-word: rst_n pulled low asynchronously after 2 pairs. Required: cuenta_o=0, A_o=0 immediately; after release, 3 new pairs produce a correct word.
- Stall: bit_valido_i gaps of 1–5 random cycles between pairs (1,0),(0,1),(1,1). Required: A_o=3'b101, B_o=3'b110 and cuenta_o increments only on accepted pairs.
